// File: rtl/cache_set_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_set_requester                                          |
// | Description : CPU-side controller for one Set array: issues Set ops,       |
// |               fills read misses from memory, answers the CPU.              |
// |               Optional macro CACHE_REQ_STATS_EN adds hit/miss/err counters.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cache_set_requester #(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [1:0]        set_enable,
  output logic [1:0]        set_write_enable,
  output logic [1:0]        set_force_write,
  output logic [5:0]        set_idx,
  output logic [ADDR_W-13:0] set_tag,
  output logic [5:0]        set_block_offset,
  output logic [1:0]        set_data_size,
  output logic [63:0]       set_write_data,
  output logic [31:0]       set_n_ops,
  input  logic [127:0]      set_out_data,
  input  logic [1:0]        set_data_ready,
  input  logic [1:0]        set_read_miss,
  input  logic [1:0]        set_write_miss,
  input  logic [1:0]        set_op_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
`ifdef CACHE_REQ_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_errs
`endif
);

  localparam int c_TMO_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FETCH = 3'd4,
    S_FILL  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [63:0]         r_wdata;
  logic                r_retry;
  logic                r_fill_op;
  logic [c_TMO_W-1:0]  r_tmo;
  logic [63:0]         r_mem_word;
  logic [31:0]         r_n_ops;

  logic [1:0]          r_set_we;
  logic [1:0]          r_set_force;
  logic [1:0]          r_set_size;
  logic [5:0]          r_set_idx;
  logic [5:0]          r_set_off;
  logic [ADDR_W-13:0]  r_set_tag;
  logic [63:0]         r_set_wdata;

  logic [63:0]         r_resp_rdata;
  logic                r_resp_err;

  logic                w_resp_load;
  logic                w_resp_err;
  logic [63:0]         w_resp_data;
  logic                w_miss_enter;
  logic                w_misaligned;
  logic                w_issue_load;
  logic                w_timeout;
  logic [63:0]         w_fill_word;
  logic                w_unused;

  function automatic logic [63:0] f_size_mask(input logic [63:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    f_size_mask = {56'd0, d[7:0]};
      2'd1:    f_size_mask = {48'd0, d[15:0]};
      2'd2:    f_size_mask = {32'd0, d[31:0]};
      default: f_size_mask = d;
    endcase
  endfunction

  function automatic logic [5:0] f_align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    f_align_mask = 6'd0;
      2'd1:    f_align_mask = 6'd1;
      2'd2:    f_align_mask = 6'd3;
      default: f_align_mask = 6'd7;
    endcase
  endfunction

  assign w_misaligned = |(r_addr[5:0] & f_align_mask(r_size));
  assign w_timeout    = (r_tmo == c_TMO_W'(TIMEOUT_CYC - 1));
  // Filled word is 8-byte aligned; shift the requested bytes down to bit 0.
  assign w_fill_word  = r_mem_word >> {r_addr[2:0], 3'b000};
  assign w_issue_load = (w_next == S_ISSUE) && (r_state != S_ISSUE);
  assign w_unused     = ^set_out_data[127:64];

  always_comb begin
    w_next       = r_state;
    w_resp_load  = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_data  = 64'd0;
    w_miss_enter = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_misaligned) begin
          w_next      = S_RESP;
          w_resp_load = 1'b1;
          w_resp_err  = 1'b1;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_FILL:  w_next = S_WAIT;
      S_WAIT: begin
        if (|set_op_done) begin
          if (r_fill_op) begin
            w_next = S_ISSUE;
          end else if (|set_write_miss) begin
            w_next      = S_RESP;
            w_resp_load = 1'b1;
            w_resp_err  = 1'b1;
          end else if (r_we) begin
            w_next      = S_RESP;
            w_resp_load = 1'b1;
          end else if (|set_read_miss) begin
            if (r_retry) begin
              w_next      = S_RESP;
              w_resp_load = 1'b1;
              w_resp_err  = 1'b1;
            end else begin
              w_next       = S_FETCH;
              w_miss_enter = 1'b1;
            end
          end else if (|set_data_ready) begin
            w_next      = S_RESP;
            w_resp_load = 1'b1;
            w_resp_data = r_retry ? f_size_mask(w_fill_word, r_size)
                                  : f_size_mask(set_out_data[63:0], r_size);
          end else begin
            // Load completed with neither data nor a miss: nothing usable.
            w_next      = S_RESP;
            w_resp_load = 1'b1;
            w_resp_err  = 1'b1;
          end
        end else if (w_timeout) begin
          w_next      = S_RESP;
          w_resp_load = 1'b1;
          w_resp_err  = 1'b1;
        end
      end
      S_FETCH: begin
        if (mem_ack) w_next = S_FILL;
      end
      S_RESP: begin
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_size       <= 2'd0;
      r_wdata      <= 64'd0;
      r_retry      <= 1'b0;
      r_fill_op    <= 1'b0;
      r_tmo        <= '0;
      r_mem_word   <= 64'd0;
      r_n_ops      <= 32'd0;
      r_set_we     <= 2'b00;
      r_set_force  <= 2'b00;
      r_set_size   <= 2'd0;
      r_set_idx    <= 6'd0;
      r_set_off    <= 6'd0;
      r_set_tag    <= '0;
      r_set_wdata  <= 64'd0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;

      if (r_state == S_IDLE && req_valid) begin
        r_we      <= req_we;
        r_addr    <= req_addr;
        r_size    <= req_size;
        r_wdata   <= req_wdata;
        r_retry   <= 1'b0;
        r_fill_op <= 1'b0;
      end

      // Original request fields, for the first attempt and the post-fill retry.
      if (w_issue_load) begin
        r_set_we    <= r_we ? 2'b01 : 2'b00;
        r_set_force <= 2'b00;
        r_set_size  <= r_size;
        r_set_idx   <= r_addr[11:6];
        r_set_off   <= r_addr[5:0];
        r_set_tag   <= r_addr[ADDR_W-1:12];
        r_set_wdata <= r_wdata;
        r_fill_op   <= 1'b0;
        if (r_state == S_WAIT) r_retry <= 1'b1;
      end

      if (r_state == S_FETCH && mem_ack) begin
        r_mem_word  <= mem_rdata;
        r_set_we    <= 2'b01;
        r_set_force <= 2'b01;
        r_set_size  <= 2'd3;
        r_set_off   <= {r_addr[5:3], 3'b000};
        r_set_wdata <= mem_rdata;
        r_fill_op   <= 1'b1;
      end

      if (r_state == S_ISSUE || r_state == S_FILL) r_n_ops <= r_n_ops + 32'd1;

      if (w_resp_load) begin
        r_resp_rdata <= w_resp_data;
        r_resp_err   <= w_resp_err;
      end
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign resp_valid       = (r_state == S_RESP);
  assign resp_rdata       = r_resp_rdata;
  assign resp_err         = r_resp_err;
  assign set_enable       = (r_state == S_ISSUE || r_state == S_FILL) ? 2'b01 : 2'b00;
  assign set_write_enable = r_set_we;
  assign set_force_write  = r_set_force;
  assign set_idx          = r_set_idx;
  assign set_tag          = r_set_tag;
  assign set_block_offset = r_set_off;
  assign set_data_size    = r_set_size;
  assign set_write_data   = r_set_wdata;
  assign set_n_ops        = r_n_ops;
  assign mem_req          = (r_state == S_FETCH);
  assign mem_addr         = mem_req ? {r_addr[ADDR_W-1:3], 3'b000} : '0;

`ifdef CACHE_REQ_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;
  logic [31:0] r_errs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits   <= 32'd0;
      r_misses <= 32'd0;
      r_errs   <= 32'd0;
    end else begin
      if (w_resp_load && w_resp_err && (r_errs != 32'hFFFF_FFFF))
        r_errs <= r_errs + 32'd1;
      if (w_resp_load && !w_resp_err && !r_retry && (r_hits != 32'hFFFF_FFFF))
        r_hits <= r_hits + 32'd1;
      if (w_miss_enter && (r_misses != 32'hFFFF_FFFF))
        r_misses <= r_misses + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
  assign stat_errs   = r_errs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_set_requester.sv
`default_nettype none
// Randomized scoreboard bench for cache_set_requester with behavioural Set and memory models.
module tb_cache_set_requester;

  localparam int K_NONE = 0, K_DONE = 1, K_HIT = 2, K_RMISS = 3, K_WMISS = 4;
  localparam int SC_LHIT = 0, SC_SHIT = 1, SC_MISS = 2, SC_DMISS = 3,
                 SC_WMISS = 4, SC_MISAL = 5, SC_TMO = 6;

  typedef struct {
    logic [1:0]  we;
    logic [1:0]  force_w;
    logic [5:0]  idx;
    logic [23:0] tag;
    logic [5:0]  off;
    logic [1:0]  size;
    logic [63:0] wdata;
    bit          chk_wdata;
    int          kind;
    logic [63:0] data;
  } op_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    bit          chk_rdata;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [35:0]  req_addr = '0;
  logic [1:0]   req_size = '0;
  logic [63:0]  req_wdata = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [63:0]  resp_rdata;
  logic         resp_err;
  logic [1:0]   set_enable, set_write_enable, set_force_write, set_data_size;
  logic [5:0]   set_idx, set_block_offset;
  logic [23:0]  set_tag;
  logic [63:0]  set_write_data;
  logic [31:0]  set_n_ops;
  logic [127:0] set_out_data = '0;
  logic [1:0]   set_data_ready = '0, set_read_miss = '0, set_write_miss = '0, set_op_done = '0;
  logic         mem_req;
  logic [35:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [63:0]  mem_rdata = '0;

  int           n_tests = 0;
  int           n_fail  = 0;
  op_t          op_q[$];
  resp_t        exp_q[$];
  logic [31:0]  exp_nops = 0;
  logic [35:0]  cur_addr = '0;
  logic [63:0]  mem [logic [35:0]];

  cache_set_requester dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .set_enable(set_enable), .set_write_enable(set_write_enable),
    .set_force_write(set_force_write), .set_idx(set_idx), .set_tag(set_tag),
    .set_block_offset(set_block_offset), .set_data_size(set_data_size),
    .set_write_data(set_write_data), .set_n_ops(set_n_ops),
    .set_out_data(set_out_data), .set_data_ready(set_data_ready),
    .set_read_miss(set_read_miss), .set_write_miss(set_write_miss),
    .set_op_done(set_op_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] size_mask(input logic [63:0] d, input logic [1:0] sz);
    if (sz == 2'd3) return d;
    return d & ((64'd1 << (8 << sz)) - 64'd1);
  endfunction

  function automatic logic [1:0] nz();
    return 2'($urandom_range(1, 3));
  endfunction

  // Backing memory: any untouched aligned word gets a deterministic address-derived value.
  function logic [63:0] mem_word(input logic [35:0] a);
    logic [35:0] k;
    k = {a[35:3], 3'b000};
    if (!mem.exists(k)) mem[k] = {~k[31:0], k[31:0]} ^ 64'h0123_4567_89AB_CDEF;
    return mem[k];
  endfunction

  // Set model: consumes one scripted op per enable strobe and answers after random latency.
  initial begin : set_model
    op_t op;
    int  lat;
    forever begin
      @(negedge clk);
      if (!rst && set_enable !== 2'b00) begin
        check("set_enable_value", set_enable, 2'b01);
        check("set_n_ops", set_n_ops, exp_nops);
        exp_nops = exp_nops + 1;
        if (op_q.size() == 0) begin
          flag_fail("unexpected_set_op");
        end else begin
          op = op_q.pop_front();
          check("set_fields",
                {set_write_enable, set_force_write, set_idx, set_tag, set_block_offset, set_data_size},
                {op.we, op.force_w, op.idx, op.tag, op.off, op.size});
          if (op.chk_wdata) check("set_write_data", set_write_data, op.wdata);
          @(negedge clk);
          check("set_enable_width", set_enable, 2'b00);
          if (op.kind != K_NONE) begin
            lat = $urandom_range(0, 3);
            repeat (lat) @(posedge clk);
            #1;
            set_op_done = nz();
            case (op.kind)
              K_HIT: begin
                set_data_ready = nz();
                set_out_data   = {$urandom, $urandom, op.data};
              end
              K_RMISS: set_read_miss  = nz();
              K_WMISS: set_write_miss = nz();
              default: ;
            endcase
            @(posedge clk);
            #1;
            set_op_done = '0; set_data_ready = '0; set_read_miss = '0; set_write_miss = '0;
            set_out_data = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
    end
  end

  initial begin : mem_model
    int lat;
    forever begin
      @(negedge clk);
      if (!rst && mem_req === 1'b1) begin
        check("mem_addr", mem_addr, {cur_addr[35:3], 3'b000});
        lat = $urandom_range(0, 3);
        repeat (lat) @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = mem_word(cur_addr);
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1 resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_response");
        end else begin
          e = exp_q.pop_front();
          check("resp_err", resp_err, e.err);
          if (e.chk_rdata) check("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [35:0] addr, input logic [1:0] sz,
                      input logic [63:0] wd);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (k == 300) flag_fail("req_ready_timeout");
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && op_q.size() == 0 && req_ready) break;
    end
    n_tests++;
    if (k == 400) begin
      n_fail++;
      $display("FAIL idle_wait: transaction still pending after 400 cycles (t=%0t)", $time);
    end
  endtask

  // Reference: build the expected Set op script and CPU response from the request.
  task automatic do_txn(input int sc, input logic [35:0] addr, input logic [1:0] sz,
                        input logic [63:0] wd, input logic [63:0] sdata);
    op_t         o, f;
    resp_t       r;
    logic [63:0] w, ext;
    cur_addr    = addr;
    o.we        = (sc == SC_SHIT || sc == SC_WMISS) ? 2'b01 : 2'b00;
    o.force_w   = 2'b00;
    o.idx       = addr[11:6];
    o.tag       = addr[35:12];
    o.off       = addr[5:0];
    o.size      = sz;
    o.wdata     = wd;
    o.chk_wdata = (o.we != 2'b00);
    o.data      = sdata;
    o.kind      = K_NONE;
    r.err = 1'b0; r.rdata = '0; r.chk_rdata = 1'b0;
    case (sc)
      SC_LHIT:  begin o.kind = K_HIT; op_q.push_back(o); r.rdata = size_mask(sdata, sz); r.chk_rdata = 1'b1; end
      SC_SHIT:  begin o.kind = K_DONE; op_q.push_back(o); end
      SC_WMISS: begin o.kind = K_WMISS; op_q.push_back(o); r.err = 1'b1; end
      SC_TMO:   begin o.kind = K_NONE; op_q.push_back(o); r.err = 1'b1; end
      SC_MISAL: r.err = 1'b1;
      default: begin
        o.kind = K_RMISS;
        op_q.push_back(o);
        w = mem_word(addr);
        f = o;
        f.we = 2'b01; f.force_w = 2'b01; f.off = {addr[5:3], 3'b000}; f.size = 2'd3;
        f.wdata = w; f.chk_wdata = 1'b1; f.kind = K_DONE;
        op_q.push_back(f);
        ext = w >> (int'(addr[2:0]) * 8);
        o.data = ext;
        o.kind = (sc == SC_DMISS) ? K_RMISS : K_HIT;
        op_q.push_back(o);
        if (sc == SC_DMISS) r.err = 1'b1;
        else begin r.rdata = size_mask(ext, sz); r.chk_rdata = 1'b1; end
      end
    endcase
    exp_q.push_back(r);
    send(o.we[0], addr, sz, wd);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          found, cnt, sc, pick, m;
    logic [63:0] t;
    logic [35:0] addr;
    logic [1:0]  sz;

    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_outputs", {resp_valid, mem_req, set_enable, resp_err}, 5'd0);
    check("reset_n_ops", set_n_ops, 32'd0);
    rst = 1'b0;

    do_txn(SC_LHIT, 36'h0_0000_1040, 2'd3, 64'h0, 64'hDEAD_BEEF_0123_4567);
    wait_idle();
    check("n_ops_after_first_load", set_n_ops, 32'd1);

    do_txn(SC_SHIT, 36'h0_0000_2046, 2'd1, 64'hABCD, 64'h0);
    wait_idle();

    mem[36'h0_0000_3008] = 64'h1122_3344_5566_7788;
    do_txn(SC_MISS, 36'h0_0000_300C, 2'd2, 64'h0, 64'h0);
    wait_idle();

    do_txn(SC_MISAL, 36'h0_0000_4003, 2'd2, 64'h0, 64'h0);
    found = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (resp_valid) found = 1;
    end
    check("misaligned_latency", found, 1);
    wait_idle();

    do_txn(SC_TMO, 36'h0_0000_5010, 2'd3, 64'h0, 64'h0);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (set_enable != 2'b00) found = 1;
    end
    cnt = 0;
    while (!resp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_latency", cnt, 17);
    wait_idle();

    do_txn(SC_MISS, 36'h0_0000_6020, 2'd3, 64'h0, 64'h0);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    check("reached_fetch", found, 1);
    #2 rst = 1'b1;
    #1;
    check("reset_in_fetch", {mem_req, req_ready, resp_valid}, 3'b010);
    op_q.delete();
    exp_q.delete();
    exp_nops = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_txn(SC_LHIT, 36'h0_0000_7008, 2'd0, 64'h0, {$urandom, $urandom});
    wait_idle();
    check("n_ops_after_reset", set_n_ops, 32'd1);

    for (int i = 0; i < 70; i++) begin
      pick = $urandom_range(0, 19);
      sc = (pick < 6) ? SC_LHIT : (pick < 10) ? SC_SHIT : (pick < 14) ? SC_MISS :
           (pick < 16) ? SC_DMISS : (pick < 18) ? SC_WMISS : (pick < 19) ? SC_MISAL : SC_TMO;
      t    = {$urandom, $urandom};
      addr = t[35:0];
      sz   = (sc == SC_MISAL) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      m    = (1 << sz) - 1;
      addr[5:0] = addr[5:0] & ~6'(m);
      if (sc == SC_MISAL) addr[5:0] = addr[5:0] | 6'($urandom_range(1, m));
      do_txn(sc, addr, sz, {$urandom, $urandom}, {$urandom, $urandom});
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
